// File: rtl/axi4_dram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi4_dram_arbiter: round-robin arbiter granting whole AXI4 bursts from   |
// | two masters onto one DRAM controller slave port.            Rev 1.0      |
// +--------------------------------------------------------------------------+
module axi4_dram_arbiter #(
   parameter int AXI4_ID_WIDTH = 4,
   parameter int ADDR_WIDTH    = 32,
   parameter int DATA_WIDTH    = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [AXI4_ID_WIDTH-1:0] i_s0_awid,   input  logic [ADDR_WIDTH-1:0]   i_s0_awaddr,
   input  logic [7:0]               i_s0_awlen,  input  logic [2:0]              i_s0_awsize,
   input  logic [1:0]               i_s0_awburst, input logic                    i_s0_awvalid,
   output logic                     o_s0_awready,
   input  logic [DATA_WIDTH-1:0]    i_s0_wdata,  input  logic [DATA_WIDTH/8-1:0] i_s0_wstrb,
   input  logic                     i_s0_wlast,  input  logic                    i_s0_wvalid,
   output logic                     o_s0_wready,
   output logic [AXI4_ID_WIDTH-1:0] o_s0_bid,    output logic [1:0]              o_s0_bresp,
   output logic                     o_s0_bvalid, input  logic                    i_s0_bready,
   input  logic [AXI4_ID_WIDTH-1:0] i_s0_arid,   input  logic [ADDR_WIDTH-1:0]   i_s0_araddr,
   input  logic [7:0]               i_s0_arlen,  input  logic [2:0]              i_s0_arsize,
   input  logic [1:0]               i_s0_arburst, input logic                    i_s0_arvalid,
   output logic                     o_s0_arready,
   output logic [AXI4_ID_WIDTH-1:0] o_s0_rid,    output logic [DATA_WIDTH-1:0]   o_s0_rdata,
   output logic [1:0]               o_s0_rresp,  output logic                    o_s0_rlast,
   output logic                     o_s0_rvalid, input  logic                    i_s0_rready,
   input  logic [AXI4_ID_WIDTH-1:0] i_s1_awid,   input  logic [ADDR_WIDTH-1:0]   i_s1_awaddr,
   input  logic [7:0]               i_s1_awlen,  input  logic [2:0]              i_s1_awsize,
   input  logic [1:0]               i_s1_awburst, input logic                    i_s1_awvalid,
   output logic                     o_s1_awready,
   input  logic [DATA_WIDTH-1:0]    i_s1_wdata,  input  logic [DATA_WIDTH/8-1:0] i_s1_wstrb,
   input  logic                     i_s1_wlast,  input  logic                    i_s1_wvalid,
   output logic                     o_s1_wready,
   output logic [AXI4_ID_WIDTH-1:0] o_s1_bid,    output logic [1:0]              o_s1_bresp,
   output logic                     o_s1_bvalid, input  logic                    i_s1_bready,
   input  logic [AXI4_ID_WIDTH-1:0] i_s1_arid,   input  logic [ADDR_WIDTH-1:0]   i_s1_araddr,
   input  logic [7:0]               i_s1_arlen,  input  logic [2:0]              i_s1_arsize,
   input  logic [1:0]               i_s1_arburst, input logic                    i_s1_arvalid,
   output logic                     o_s1_arready,
   output logic [AXI4_ID_WIDTH-1:0] o_s1_rid,    output logic [DATA_WIDTH-1:0]   o_s1_rdata,
   output logic [1:0]               o_s1_rresp,  output logic                    o_s1_rlast,
   output logic                     o_s1_rvalid, input  logic                    i_s1_rready,
   output logic [AXI4_ID_WIDTH-1:0] o_m_awid,    output logic [ADDR_WIDTH-1:0]   o_m_awaddr,
   output logic [7:0]               o_m_awlen,   output logic [2:0]              o_m_awsize,
   output logic [1:0]               o_m_awburst, output logic                    o_m_awvalid,
   input  logic                     i_m_awready,
   output logic [DATA_WIDTH-1:0]    o_m_wdata,   output logic [DATA_WIDTH/8-1:0] o_m_wstrb,
   output logic                     o_m_wlast,   output logic                    o_m_wvalid,
   input  logic                     i_m_wready,
   input  logic [AXI4_ID_WIDTH-1:0] i_m_bid,     input  logic [1:0]              i_m_bresp,
   input  logic                     i_m_bvalid,  output logic                    o_m_bready,
   output logic [AXI4_ID_WIDTH-1:0] o_m_arid,    output logic [ADDR_WIDTH-1:0]   o_m_araddr,
   output logic [7:0]               o_m_arlen,   output logic [2:0]              o_m_arsize,
   output logic [1:0]               o_m_arburst, output logic                    o_m_arvalid,
   input  logic                     i_m_arready,
   input  logic [AXI4_ID_WIDTH-1:0] i_m_rid,     input  logic [DATA_WIDTH-1:0]   i_m_rdata,
   input  logic [1:0]               i_m_rresp,   input  logic                    i_m_rlast,
   input  logic                     i_m_rvalid,  output logic                    o_m_rready
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      W_ADDR = 3'd1,
      W_DATA = 3'd2,
      W_RESP = 3'd3,
      R_ADDR = 3'd4,
      R_DATA = 3'd5
   } state_t;

   state_t r_state, w_state_nxt;
   logic   r_gnt, w_gnt_nxt, r_rr_last, w_rr_nxt, w_pick;
   logic   w_req0, w_req1;

   assign w_req0 = i_s0_awvalid | i_s0_arvalid;
   assign w_req1 = i_s1_awvalid | i_s1_arvalid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_gnt     <= 1'b0;
         r_rr_last <= 1'b1;
      end else begin
         r_state   <= w_state_nxt;
         r_gnt     <= w_gnt_nxt;
         r_rr_last <= w_rr_nxt;
      end
   end

   // Every forwarded signal is zero unless its channel is the active phase.
   always_comb begin
      w_state_nxt = r_state;   w_gnt_nxt = r_gnt;   w_rr_nxt = r_rr_last;   w_pick = 1'b0;
      o_m_awid = '0;  o_m_awaddr = '0;  o_m_awlen = '0;  o_m_awsize = '0;  o_m_awburst = '0;
      o_m_awvalid = 1'b0;  o_m_wdata = '0;  o_m_wstrb = '0;  o_m_wlast = 1'b0;  o_m_wvalid = 1'b0;
      o_m_bready = 1'b0;  o_m_arid = '0;  o_m_araddr = '0;  o_m_arlen = '0;  o_m_arsize = '0;
      o_m_arburst = '0;  o_m_arvalid = 1'b0;  o_m_rready = 1'b0;
      o_s0_awready = 1'b0;  o_s0_wready = 1'b0;  o_s0_bid = '0;  o_s0_bresp = '0;  o_s0_bvalid = 1'b0;
      o_s0_arready = 1'b0;  o_s0_rid = '0;  o_s0_rdata = '0;  o_s0_rresp = '0;  o_s0_rlast = 1'b0;
      o_s0_rvalid = 1'b0;
      o_s1_awready = 1'b0;  o_s1_wready = 1'b0;  o_s1_bid = '0;  o_s1_bresp = '0;  o_s1_bvalid = 1'b0;
      o_s1_arready = 1'b0;  o_s1_rid = '0;  o_s1_rdata = '0;  o_s1_rresp = '0;  o_s1_rlast = 1'b0;
      o_s1_rvalid = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_req0 || w_req1) begin
               w_pick      = (w_req0 && w_req1) ? ~r_rr_last : w_req1;
               w_gnt_nxt   = w_pick;
               w_rr_nxt    = w_pick;
               w_state_nxt = (w_pick ? i_s1_awvalid : i_s0_awvalid) ? W_ADDR : R_ADDR;
            end
         end
         W_ADDR: begin
            o_m_awid     = r_gnt ? i_s1_awid    : i_s0_awid;
            o_m_awaddr   = r_gnt ? i_s1_awaddr  : i_s0_awaddr;
            o_m_awlen    = r_gnt ? i_s1_awlen   : i_s0_awlen;
            o_m_awsize   = r_gnt ? i_s1_awsize  : i_s0_awsize;
            o_m_awburst  = r_gnt ? i_s1_awburst : i_s0_awburst;
            o_m_awvalid  = r_gnt ? i_s1_awvalid : i_s0_awvalid;
            o_s0_awready = ~r_gnt & i_m_awready;
            o_s1_awready =  r_gnt & i_m_awready;
            if (o_m_awvalid && i_m_awready) w_state_nxt = W_DATA;
         end
         W_DATA: begin
            o_m_wdata   = r_gnt ? i_s1_wdata  : i_s0_wdata;
            o_m_wstrb   = r_gnt ? i_s1_wstrb  : i_s0_wstrb;
            o_m_wlast   = r_gnt ? i_s1_wlast  : i_s0_wlast;
            o_m_wvalid  = r_gnt ? i_s1_wvalid : i_s0_wvalid;
            o_s0_wready = ~r_gnt & i_m_wready;
            o_s1_wready =  r_gnt & i_m_wready;
            // Burst end is taken from WLAST alone; beats are not counted.
            if (o_m_wvalid && i_m_wready && o_m_wlast) w_state_nxt = W_RESP;
         end
         W_RESP: begin
            if (r_gnt) begin
               o_s1_bid = i_m_bid;  o_s1_bresp = i_m_bresp;  o_s1_bvalid = i_m_bvalid;
               o_m_bready = i_s1_bready;
            end else begin
               o_s0_bid = i_m_bid;  o_s0_bresp = i_m_bresp;  o_s0_bvalid = i_m_bvalid;
               o_m_bready = i_s0_bready;
            end
            if (i_m_bvalid && o_m_bready) w_state_nxt = IDLE;
         end
         R_ADDR: begin
            o_m_arid     = r_gnt ? i_s1_arid    : i_s0_arid;
            o_m_araddr   = r_gnt ? i_s1_araddr  : i_s0_araddr;
            o_m_arlen    = r_gnt ? i_s1_arlen   : i_s0_arlen;
            o_m_arsize   = r_gnt ? i_s1_arsize  : i_s0_arsize;
            o_m_arburst  = r_gnt ? i_s1_arburst : i_s0_arburst;
            o_m_arvalid  = r_gnt ? i_s1_arvalid : i_s0_arvalid;
            o_s0_arready = ~r_gnt & i_m_arready;
            o_s1_arready =  r_gnt & i_m_arready;
            if (o_m_arvalid && i_m_arready) w_state_nxt = R_DATA;
         end
         R_DATA: begin
            if (r_gnt) begin
               o_s1_rid = i_m_rid;  o_s1_rdata = i_m_rdata;  o_s1_rresp = i_m_rresp;
               o_s1_rlast = i_m_rlast;  o_s1_rvalid = i_m_rvalid;  o_m_rready = i_s1_rready;
            end else begin
               o_s0_rid = i_m_rid;  o_s0_rdata = i_m_rdata;  o_s0_rresp = i_m_rresp;
               o_s0_rlast = i_m_rlast;  o_s0_rvalid = i_m_rvalid;  o_m_rready = i_s0_rready;
            end
            if (i_m_rvalid && o_m_rready && i_m_rlast) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

endmodule
`default_nettype wire
